shade_reflect_pipe: RTL and testbench
=====================================

SHADE_REFLECT_PIPE -- requirements
Module: shade_reflect_pipe

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: fixed latency of fp32_mul in cycles (op_vld to result_vld).
REQ-002 SHALL have parameter ADD_LAT, default 4: fixed latency of fp32_add in cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: output buffer entries, power of two, at least 2.
REQ-004 SHALL have parameter TAG_W, default 16: width of the ray tag passed through.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 in_vld  input  1  input beat valid.
REQ-009 in_rdy  output  1  block can accept a beat.
REQ-010 in_mode  input  1  0 = SPEC (-2·ndotd·n), 1 = REFLECT (d - 2·ndotd·n).
REQ-011 in_tag  input  TAG_W  opaque ray id.
REQ-012 n_dot_d  input  32  fp32 dot(n,d).
REQ-013 n  input  vec3_t  surface normal.
REQ-014 d  input  vec3_t  incident direction.
REQ-015 out_vld  output  1  result beat valid.
REQ-016 out_rdy  input  1  consumer accepts the beat.
REQ-017 out_tag  output  TAG_W  tag of the result beat.
REQ-018 result  output  vec3_t  fp32 result direction.

Function
REQ-019 A beat SHALL be accepted exactly on cycles where in_vld and in_rdy are both 1; output transfers SHALL occur where out_vld and out_rdy are both 1.
REQ-020 Stage A SHALL compute s = n_dot_d × -2.0 (one fp32_mul); stage B SHALL compute p = n × s per component (three fp32_mul); stage C SHALL compute q = d + p per component (three fp32_add).
REQ-021 Pipeline latency from accept to FIFO write SHALL be L = 2·MUL_LAT + ADD_LAT cycles, regardless of mode.
REQ-022 d, in_mode and in_tag SHALL be carried through valid-qualified delay registers aligned to their stage, with no recomputation.
REQ-023 In SPEC mode the result SHALL be p bit-exact, delayed ADD_LAT cycles; in REFLECT mode it SHALL be q.
REQ-024 The pipeline SHALL never stall; each pipeline result SHALL be written to the FIFO on the cycle it emerges.
REQ-025 A credit counter cnt (width clog2(FIFO_DEPTH)+1) SHALL track in-flight plus FIFO-resident beats: +1 on accept, -1 on output transfer, unchanged when both occur.
REQ-026 in_rdy SHALL be (cnt < FIFO_DEPTH), registered-free and combinational from cnt only, never from in_vld.
REQ-027 When cnt == FIFO_DEPTH and an output transfer happens, in_rdy SHALL stay 0 that cycle and rise the next cycle.
REQ-028 The FIFO SHALL be first-word-fall-through: out_vld = not empty, result/out_tag valid in the same cycle; pointers wrap modulo FIFO_DEPTH.
REQ-029 A FIFO write and read in the same cycle SHALL both take effect, including on an empty FIFO at the cycle of write (data visible the next cycle).
REQ-030 Output order SHALL equal input order; fp32 rounding and special values SHALL be as produced by fp32_mul/fp32_add.

Reset
REQ-031 While rst_n = 0: cnt = 0, FIFO empty, all stage valids 0, out_vld = 0, in_rdy = 0.
REQ-032 in_rdy SHALL be 1 on the first cycle after rst_n returns to 1; result and out_tag are don't-care while out_vld = 0.
REQ-033 Reset mid-operation SHALL discard every in-flight and buffered beat, with no output after reset release until a new accept.

Structure
REQ-034 vec3_t, fp32_t and FP32_MINUS_TWO (32'hc0000000) SHALL live in the shared defines package.
REQ-035 The output buffer SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH) instantiated once with WIDTH = 96 + TAG_W.

Verification
REQ-036 REFLECT mode, n=(0,1,0), d=(1,-1,0), n_dot_d=-1.0 -> after L+1 cycles result = (3f800000, 3f800000, 00000000).
REQ-037 SPEC mode, same inputs -> result = (00000000, 40000000, 00000000), tag preserved; a mixed back-to-back mode stream returns in order with correct per-beat mode.
REQ-038 out_rdy=0, in_vld=1 continuously -> exactly FIFO_DEPTH beats accepted, then in_rdy=0; out_rdy=1 -> all 16 drain in order, in_rdy rises the cycle after the first pop.
REQ-039 cnt full, accept-attempt and pop in the same cycle -> no accept that cycle, in_rdy=1 next cycle, cnt = FIFO_DEPTH-1.
REQ-040 rst_n low for 1 cycle with 3 beats in flight and 2 buffered -> out_vld stays 0 afterwards, and a new beat returns after L+1 cycles.
REQ-041 Random in_vld/out_rdy for 10k beats vs a C reference model -> bit-exact results, no loss or duplication, and cnt never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/shade_reflect_pipe_pkg.sv
// Shared fp32 types and the arithmetic behind the fp32_mul / fp32_add stages.
// Normal numbers round to nearest-even; subnormals flush to zero, overflow saturates to infinity.
package shade_reflect_pipe_pkg;

   typedef logic [31:0] fp32_t;

   typedef struct packed {
      fp32_t x;
      fp32_t y;
      fp32_t z;
   } vec3_t;

   localparam fp32_t FP32_MINUS_TWO = 32'hc000_0000;
   localparam fp32_t FP32_QNAN      = 32'h7fc0_0000;

   function automatic fp32_t fp32_round(input logic sign, input int exp_in,
                                        input logic [23:0] mant, input logic g, input logic s);
      logic [24:0] m;
      int          e;
      e = exp_in;
      m = {1'b0, mant} + {24'b0, g & (s | mant[0])};
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {sign, 8'hff, 23'b0};
      if (e <= 0)   return {sign, 31'b0};
      return {sign, e[7:0], m[22:0]};
   endfunction

   function automatic fp32_t fp32_mul(input fp32_t a, input fp32_t b);
      logic        sign;
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [47:0] prod;
      int          e;
      sign   = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hff) && (a[22:0] != '0);
      b_nan  = (b[30:23] == 8'hff) && (b[22:0] != '0);
      a_inf  = (a[30:23] == 8'hff) && (a[22:0] == '0);
      b_inf  = (b[30:23] == 8'hff) && (b[22:0] == '0);
      a_zero = (a[30:23] == '0);
      b_zero = (b[30:23] == '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP32_QNAN;
      if (a_inf || b_inf)   return {sign, 8'hff, 23'b0};
      if (a_zero || b_zero) return {sign, 31'b0};
      prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e    = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (prod[47]) return fp32_round(sign, e + 1, prod[47:24], prod[23], |prod[22:0]);
      return fp32_round(sign, e, prod[46:23], prod[22], |prod[21:0]);
   endfunction

   function automatic fp32_t fp32_add(input fp32_t a, input fp32_t b);
      fp32_t       big, sml;
      logic [26:0] bx, sx, shifted, r;
      logic [27:0] sum;
      int          dexp, e, lz;
      logic        hit;
      if (((a[30:23] == 8'hff) && (a[22:0] != '0)) ||
          ((b[30:23] == 8'hff) && (b[22:0] != '0))) return FP32_QNAN;
      if ((a[30:23] == 8'hff) && (b[30:23] == 8'hff) && (a[31] != b[31])) return FP32_QNAN;
      if (a[30:23] == 8'hff) return a;
      if (b[30:23] == 8'hff) return b;
      if ((a[30:23] == '0) && (b[30:23] == '0)) return {a[31] & b[31], 31'b0};
      if (a[30:23] == '0) return b;
      if (b[30:23] == '0) return a;
      if (a[30:0] < b[30:0]) begin
         big = b;
         sml = a;
      end else begin
         big = a;
         sml = b;
      end
      dexp = int'(big[30:23]) - int'(sml[30:23]);
      e    = int'(big[30:23]);
      bx   = {1'b1, big[22:0], 3'b000};
      sx   = {1'b1, sml[22:0], 3'b000};
      // guard/round/sticky in the low three bits; bits shifted out collapse into sticky
      if (dexp >= 27) begin
         shifted = 27'd1;
      end else begin
         shifted = sx >> dexp;
         if ((sx << (27 - dexp)) != '0) shifted[0] = 1'b1;
      end
      if (big[31] == sml[31]) begin
         sum = {1'b0, bx} + {1'b0, shifted};
         if (sum[27]) begin
            r    = sum[27:1];
            r[0] = r[0] | sum[0];
            e    = e + 1;
         end else begin
            r = sum[26:0];
         end
      end else begin
         r = bx - shifted;
         if (r == '0) return '0;
         lz  = 0;
         hit = 1'b0;
         for (int unsigned i = 0; i < 27; i++) begin
            if (!hit) begin
               if (r[26 - i]) hit = 1'b1;
               else           lz  = lz + 1;
            end
         end
         r = r << lz;
         e = e - lz;
      end
      return fp32_round(big[31], e, r[26:3], r[2], |r[1:0]);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; DEPTH must be a power of two so the extra pointer bit
// distinguishes full from empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)          wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/shade_reflect_pipe.sv
// Specular / reflection direction pipeline: s = -2*ndotd, p = n*s, q = d + p,
// feeding a credit-protected output FIFO so the arithmetic never stalls.
module shade_reflect_pipe
   import shade_reflect_pipe_pkg::*;
#(
   parameter int unsigned MUL_LAT    = 4,
   parameter int unsigned ADD_LAT    = 4,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TAG_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   input  fp32_t            n_dot_d,
   input  vec3_t            n,
   input  vec3_t            d,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [TAG_W-1:0] out_tag,
   output vec3_t            result
);

   localparam int unsigned ML = MUL_LAT - 1;
   localparam int unsigned AL = ADD_LAT - 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned FW = 96 + TAG_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [CW-1:0] cnt;
   logic          accept;
   logic          pop;

   logic             a_vld  [MUL_LAT];
   fp32_t            a_s    [MUL_LAT];
   vec3_t            a_n    [MUL_LAT];
   vec3_t            a_d    [MUL_LAT];
   logic             a_mode [MUL_LAT];
   logic [TAG_W-1:0] a_tag  [MUL_LAT];

   logic             b_vld  [MUL_LAT];
   vec3_t            b_p    [MUL_LAT];
   vec3_t            b_d    [MUL_LAT];
   logic             b_mode [MUL_LAT];
   logic [TAG_W-1:0] b_tag  [MUL_LAT];

   logic             c_vld  [ADD_LAT];
   vec3_t            c_q    [ADD_LAT];
   vec3_t            c_p    [ADD_LAT];
   logic             c_mode [ADD_LAT];
   logic [TAG_W-1:0] c_tag  [ADD_LAT];

   logic          wr_en;
   logic [FW-1:0] wr_data;
   logic [FW-1:0] rd_data;
   logic          empty;

   // credits cover in-flight plus buffered beats, so every pipeline result has a FIFO slot
   assign in_rdy = rst_n && (cnt < DEPTH_C);
   assign accept = in_vld && in_rdy;
   assign pop    = out_vld && out_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n)              cnt <= '0;
      else if (accept && !pop) cnt <= cnt + CW'(1);
      else if (pop && !accept) cnt <= cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            a_vld[i] <= 1'b0;
            b_vld[i] <= 1'b0;
         end
         for (int unsigned i = 0; i < ADD_LAT; i++) c_vld[i] <= 1'b0;
      end else begin
         a_vld[0] <= accept;
         b_vld[0] <= a_vld[ML];
         c_vld[0] <= b_vld[ML];
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            a_vld[i] <= a_vld[i-1];
            b_vld[i] <= b_vld[i-1];
         end
         for (int unsigned i = 1; i < ADD_LAT; i++) c_vld[i] <= c_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_s[0]    <= fp32_mul(n_dot_d, FP32_MINUS_TWO);
         a_n[0]    <= n;
         a_d[0]    <= d;
         a_mode[0] <= in_mode;
         a_tag[0]  <= in_tag;
      end
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
         if (a_vld[i-1]) begin
            a_s[i]    <= a_s[i-1];
            a_n[i]    <= a_n[i-1];
            a_d[i]    <= a_d[i-1];
            a_mode[i] <= a_mode[i-1];
            a_tag[i]  <= a_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (a_vld[ML]) begin
         b_p[0].x  <= fp32_mul(a_n[ML].x, a_s[ML]);
         b_p[0].y  <= fp32_mul(a_n[ML].y, a_s[ML]);
         b_p[0].z  <= fp32_mul(a_n[ML].z, a_s[ML]);
         b_d[0]    <= a_d[ML];
         b_mode[0] <= a_mode[ML];
         b_tag[0]  <= a_tag[ML];
      end
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
         if (b_vld[i-1]) begin
            b_p[i]    <= b_p[i-1];
            b_d[i]    <= b_d[i-1];
            b_mode[i] <= b_mode[i-1];
            b_tag[i]  <= b_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (b_vld[ML]) begin
         c_q[0].x  <= fp32_add(b_d[ML].x, b_p[ML].x);
         c_q[0].y  <= fp32_add(b_d[ML].y, b_p[ML].y);
         c_q[0].z  <= fp32_add(b_d[ML].z, b_p[ML].z);
         c_p[0]    <= b_p[ML];
         c_mode[0] <= b_mode[ML];
         c_tag[0]  <= b_tag[ML];
      end
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
         if (c_vld[i-1]) begin
            c_q[i]    <= c_q[i-1];
            c_p[i]    <= c_p[i-1];
            c_mode[i] <= c_mode[i-1];
            c_tag[i]  <= c_tag[i-1];
         end
      end
   end

   assign wr_en   = c_vld[AL];
   assign wr_data = {c_tag[AL], c_mode[AL] ? c_q[AL] : c_p[AL]};

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .empty   (empty)
   );

   assign out_vld           = !empty;
   assign {out_tag, result} = rd_data;

endmodule

// File: tb/tb_shade_reflect_pipe.sv
// Scoreboard bench: expected beats come from real-arithmetic rounding to fp32 and are
// queued on accept, then compared in order when the DUT hands a beat out.
module tb_shade_reflect_pipe;
   import shade_reflect_pipe_pkg::*;

   localparam int MUL_LAT    = 4;
   localparam int ADD_LAT    = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int TAG_W      = 16;
   localparam int L          = 2 * MUL_LAT + ADD_LAT;

   logic             clk;
   logic             rst_n;
   logic             in_vld;
   logic             in_rdy;
   logic             in_mode;
   logic [TAG_W-1:0] in_tag;
   fp32_t            n_dot_d;
   vec3_t            n;
   vec3_t            d;
   logic             out_vld;
   logic             out_rdy;
   logic [TAG_W-1:0] out_tag;
   vec3_t            result;

   int n_vec = 0;
   int n_err = 0;
   int occ   = 0;
   int n_acc = 0;
   int n_pop = 0;
   logic [TAG_W+95:0] exp_q [$];

   shade_reflect_pipe #(
      .MUL_LAT    (MUL_LAT),
      .ADD_LAT    (ADD_LAT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TAG_W      (TAG_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_mode (in_mode),
      .in_tag  (in_tag),
      .n_dot_d (n_dot_d),
      .n       (n),
      .d       (d),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_tag (out_tag),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:23] == 8'h00) b = {f[31], 63'b0};
      else                   b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      logic [24:0] m;
      int          e;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) return {b[63], 31'b0};
      e = int'(b[62:52]) - 896;
      m = {2'b01, b[51:29]};
      if (b[28] && ((|b[27:0]) || b[29])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      return {b[63], e[7:0], m[22:0]};
   endfunction

   function automatic logic [TAG_W+95:0] exp_beat(input logic mode, input logic [TAG_W-1:0] tag,
                                                  input logic [31:0] ndd, input vec3_t nv, input vec3_t dv);
      logic [31:0] s;
      vec3_t       p, q;
      s   = r2f(f2r(ndd) * -2.0);
      p.x = r2f(f2r(nv.x) * f2r(s));
      p.y = r2f(f2r(nv.y) * f2r(s));
      p.z = r2f(f2r(nv.z) * f2r(s));
      q.x = r2f(f2r(dv.x) + f2r(p.x));
      q.y = r2f(f2r(dv.y) + f2r(p.y));
      q.z = r2f(f2r(dv.z) + f2r(p.z));
      return {tag, mode ? q : p};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r = $urandom;
      return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
   endfunction

   task automatic rand_beat();
      in_mode = 1'($urandom_range(0, 1));
      in_tag  = TAG_W'($urandom);
      n_dot_d = rand_fp();
      n.x = rand_fp(); n.y = rand_fp(); n.z = rand_fp();
      d.x = rand_fp(); d.y = rand_fp(); d.z = rand_fp();
   endtask

   // book the handshakes that the coming edge performs, then step past it
   task automatic tick();
      logic acc, pop;
      acc = in_vld && in_rdy;
      pop = out_vld && out_rdy;
      if (rst_n) check_val("in_rdy", in_rdy, occ < FIFO_DEPTH);
      if (acc) begin
         exp_q.push_back(exp_beat(in_mode, in_tag, n_dot_d, n, d));
         occ++;
         n_acc++;
      end
      if (pop) begin
         if (exp_q.size() == 0) check_val("spurious_out_vld", out_vld, 0);
         else                   check_val("beat", {out_tag, result}, exp_q.pop_front());
         occ--;
         n_pop++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic measure_latency(input string tag);
      int lat;
      in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
      lat = 1;
      while (!out_vld && lat < 100) begin
         tick();
         lat++;
      end
      check_val(tag, lat, L + 1);
   endtask

   task automatic drain(input string tag);
      int guard;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      guard   = 0;
      while ((exp_q.size() > 0 || out_vld) && guard < 200) begin
         tick();
         guard++;
      end
      check_val(tag, exp_q.size(), 0);
      out_rdy = 1'b0;
   endtask

   initial begin
      int n0, p0, ghosts, cyc;
      rst_n = 1'b0; in_vld = 1'b0; in_mode = 1'b0; in_tag = '0;
      n_dot_d = '0; n = '0; d = '0; out_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_rdy", in_rdy, 0);
      check_val("rst_out_vld", out_vld, 0);
      rst_n = 1'b1;
      #1;
      check_val("in_rdy_after_rst", in_rdy, 1);

      in_mode = 1'b1; in_tag = 16'h00a1; n_dot_d = 32'hbf80_0000;
      n = {32'h0000_0000, 32'h3f80_0000, 32'h0000_0000};
      d = {32'h3f80_0000, 32'hbf80_0000, 32'h0000_0000};
      measure_latency("reflect_latency");
      check_val("reflect_vec", result, 96'h3f800000_3f800000_00000000);
      check_val("reflect_tag", out_tag, 16'h00a1);
      drain("reflect_drain");

      in_mode = 1'b0; in_tag = 16'h00b2;
      measure_latency("spec_latency");
      check_val("spec_vec", result, 96'h00000000_40000000_00000000);
      check_val("spec_tag", out_tag, 16'h00b2);
      drain("spec_drain");

      out_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         rand_beat();
         in_mode = 1'(i % 2);
         in_vld  = 1'b1;
         tick();
      end
      drain("mixed_drain");

      n0 = n_acc;
      in_vld = 1'b1;
      repeat (40) begin
         rand_beat();
         tick();
      end
      in_vld = 1'b0;
      check_val("fill_count", n_acc - n0, FIFO_DEPTH);
      check_val("full_in_rdy", in_rdy, 0);
      p0 = n_pop;
      out_rdy = 1'b1;
      check_val("rdy_on_pop_cycle", in_rdy, 0);
      tick();
      check_val("rdy_after_pop", in_rdy, 1);
      drain("fill_drain");
      check_val("fill_pop_count", n_pop - p0, FIFO_DEPTH);

      in_vld = 1'b1;
      repeat (40) begin
         rand_beat();
         tick();
      end
      rand_beat();
      n0 = n_acc;
      out_rdy = 1'b1;
      check_val("full_pop_no_rdy", in_rdy, 0);
      tick();
      check_val("full_pop_no_accept", n_acc - n0, 0);
      check_val("full_pop_rdy_next", in_rdy, 1);
      out_rdy = 1'b0;
      rand_beat();
      tick();
      in_vld = 1'b0;
      check_val("refill_to_full", in_rdy, 0);
      drain("full_pop_drain");

      in_vld = 1'b1;
      repeat (2) begin
         rand_beat();
         tick();
      end
      in_vld = 1'b0;
      repeat (L + 2) tick();
      in_vld = 1'b1;
      repeat (3) begin
         rand_beat();
         tick();
      end
      in_vld = 1'b0;
      rst_n  = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      occ = 0;
      #1;
      out_rdy = 1'b1;
      ghosts  = 0;
      repeat (30) begin
         if (out_vld) ghosts++;
         tick();
      end
      check_val("no_ghost_after_reset", ghosts, 0);
      out_rdy = 1'b0;
      rand_beat();
      measure_latency("post_reset_latency");
      drain("post_reset_drain");

      n0  = n_acc;
      cyc = 0;
      while (n_acc - n0 < 10000 && cyc < 60000) begin
         rand_beat();
         in_vld  = ($urandom_range(0, 9) < 7);
         out_rdy = ($urandom_range(0, 9) < 7);
         tick();
         cyc++;
      end
      check_val("rand_accept_count", n_acc - n0, 10000);
      drain("rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
